wr_resp_router_2m: RTL and testbench
====================================

// Module: wr_resp_router_2m
// PURPOSE
//  Write-response (B channel) return path for the 2-master write interconnect.
//  - The write-data mux steers W beats from a master to the slave; this block routes
//    the slave's B responses back to the master that issued each write.
//  - Order of issue is recorded in an in-order FIFO at each AW grant.
//  - Each response goes out through one registered stage to S00 or S01.
// PARAMETERS
//  DEPTH   4  max outstanding writes tracked (power of 2, >=2)
//  RESP_W  2  bresp width (AXI OKAY/EXOKAY/SLVERR/DECERR)
// PORTS
//  ACLK             in   1       clock; all logic on rising edge
//  ARESETN          in   1       synchronous, active-low reset
//  aw_push          in   1       AW handshake completed toward slave (grant event)
//  aw_master        in   1       master index of that AW (0=S00, 1=S01)
//  aw_ready         out  1       order FIFO not full; arbiter must not grant AW when 0
//  M_AXI_bvalid     in   1       response valid from slave
//  M_AXI_bresp      in   RESP_W  response code from slave
//  M_AXI_bready     out  1       ready to slave
//  S00_AXI_bvalid   out  1       response valid to master 0
//  S00_AXI_bresp    out  RESP_W  response code to master 0
//  S00_AXI_bready   in   1       master 0 ready
//  S01_AXI_bvalid   out  1       response valid to master 1
//  S01_AXI_bresp    out  RESP_W  response code to master 1
//  S01_AXI_bready   in   1       master 1 ready
//  outstanding      out  $clog2(DEPTH)+1  count of writes awaiting a response
// BEHAVIOUR
//  Reset: all outputs low (bvalid=0, bresp=0, bready=0, outstanding=0). FIFO empties.
//    Output stage goes to IDLE. Reset mid-burst discards pending entries and any held response.
//  Order FIFO:
//    - Push aw_master when aw_push && aw_ready.
//    - aw_ready = !full, registered-state based.
//    - Full and pop in the same cycle: aw_ready stays 0 that cycle (no bypass).
//    - aw_push while aw_ready=0: ignored; the bench flags it as a protocol error.
//    - Pointers wrap modulo DEPTH. outstanding = FIFO count, +1/-1/0 per push/pop combination.
//  Output stage FSM (one register holding resp and dest):
//    IDLE: M_AXI_bready = !empty.
//      On bvalid && bready: latch bresp, dest = FIFO head, pop -> HOLD.
//    HOLD: drive S0{dest}_AXI_bvalid=1 and bresp; the other master sees bvalid=0.
//      dest bready=1 with a new response acceptable (bvalid && !empty_after_pop):
//        reload in the same cycle, pop, stay HOLD.
//      dest bready=1 otherwise: -> IDLE.
//      dest bready=0: hold value stable (AXI: bvalid must not drop).
//      M_AXI_bready = dest_bready && fifo_count>=1 (no entry consumed twice).
//  Latency: slave B handshake at cycle N -> master bvalid at N+1.
//    Sustained throughput is 1 response/cycle while the destination is ready.
//  Empty FIFO: M_AXI_bready=0. A stray slave response is never accepted and never routed.
//  Simultaneous push and pop on empty FIFO:
//    - The push is not visible to the pop until the next cycle (no fall-through).
//    - outstanding is unchanged.
//  bresp is passed through unmodified. The non-selected master's bresp is driven 0.
// STRUCTURE
//  Package wr_resp_router_pkg:
//    - typedef enum logic [1:0] resp_e {OKAY, EXOKAY, SLVERR, DECERR}
//    - typedef logic mst_idx_t
//    - typedef enum logic {ST_IDLE, ST_HOLD} bstate_e
//  Sub-module wr_order_fifo:
//    - sync FIFO: DEPTH x 1 bit, push/pop, full/empty/count, same ACLK/ARESETN.
//  Top: FSM + output register + ready logic.
// TESTING
//  1. Reset: ARESETN=0 for 3 cycles with M_AXI_bvalid=1
//     -> all bvalid=0, M_AXI_bready=0, outstanding=0.
//  2. Push m0 then m1; slave returns OKAY then SLVERR(2'b10), both masters ready
//     -> S00 bvalid/OKAY at N+1, S01 bvalid/bresp=2'b10 at N+2, outstanding 2->0.
//  3. Push m1; S01_AXI_bready=0 for 5 cycles
//     -> S01 bvalid=1, bresp stable all 5 cycles; M_AXI_bready=0 until accept; S00 bvalid never 1.
//  4. Push 4x (m0,m1,m0,m1) -> aw_ready=0, outstanding=4.
//     Responses back-to-back -> 4 routed in order; aw_ready returns 1 after first pop.
//  5. M_AXI_bvalid=1 with empty FIFO for 4 cycles
//     -> M_AXI_bready=0 throughout, no master bvalid.
//  6. ARESETN low while in HOLD with 2 entries queued
//     -> next cycle outputs idle, outstanding=0, next push/response routes correctly.

Source files
------------

// File: rtl/wr_resp_router_pkg.sv
// Shared types for the 2-master write-response return path.
package wr_resp_router_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef logic mst_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } bstate_e;

endpackage

// File: rtl/wr_order_fifo.sv
// In-order record of which master issued each granted AW; head is the owner
// of the next slave B response.
module wr_order_fifo
  import wr_resp_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   push,
  input  mst_idx_t               push_data,
  input  logic                   pop,
  output mst_idx_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mst_idx_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flags come from registered count only, so a pop never frees a slot
  // for a push in the same cycle and a push is never visible to a pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wr_resp_router_2m.sv
// Routes slave B responses back to the issuing master through one
// registered stage, using the AW-grant order recorded in wr_order_fifo.
module wr_resp_router_2m
  import wr_resp_router_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RESP_W = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   aw_push,
  input  mst_idx_t               aw_master,
  output logic                   aw_ready,
  input  logic                   M_AXI_bvalid,
  input  logic [RESP_W-1:0]      M_AXI_bresp,
  output logic                   M_AXI_bready,
  output logic                   S00_AXI_bvalid,
  output logic [RESP_W-1:0]      S00_AXI_bresp,
  input  logic                   S00_AXI_bready,
  output logic                   S01_AXI_bvalid,
  output logic [RESP_W-1:0]      S01_AXI_bresp,
  input  logic                   S01_AXI_bready,
  output logic [$clog2(DEPTH):0] outstanding,
  output bstate_e                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and a raised valid holds its payload
  // stable until the transfer.

  bstate_e           state_q;
  bstate_e           state_d;
  logic [RESP_W-1:0] resp_q;
  mst_idx_t          dest_q;
  mst_idx_t          fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dest_bready;
  logic              accept;

  wr_order_fifo #(
    .DEPTH(DEPTH)
  ) u_order_fifo (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (aw_push),
    .push_data (aw_master),
    .pop       (accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  assign aw_ready    = !fifo_full;
  assign dest_bready = dest_q ? S01_AXI_bready : S00_AXI_bready;
  assign accept      = M_AXI_bvalid && M_AXI_bready;
  assign dbg_state   = state_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (dest_bready && !accept) state_d = ST_IDLE;
    endcase
  end

  // Every accepted slave response reloads the stage, whether from IDLE or
  // as a same-cycle replacement while the destination drains the old one.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      resp_q <= '0;
      dest_q <= 1'b0;
    end else if (accept) begin
      resp_q <= M_AXI_bresp;
      dest_q <= fifo_head;
    end
  end

  always_comb begin
    M_AXI_bready   = 1'b0;
    S00_AXI_bvalid = 1'b0;
    S00_AXI_bresp  = '0;
    S01_AXI_bvalid = 1'b0;
    S01_AXI_bresp  = '0;
    case (state_q)
      ST_IDLE: M_AXI_bready = !fifo_empty;
      ST_HOLD: begin
        M_AXI_bready = dest_bready && !fifo_empty;
        if (dest_q == 1'b0) begin
          S00_AXI_bvalid = 1'b1;
          S00_AXI_bresp  = resp_q;
        end else begin
          S01_AXI_bvalid = 1'b1;
          S01_AXI_bresp  = resp_q;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_wr_resp_router_2m.sv
// Scenario and randomized checks of wr_resp_router_2m against a queue-based model.
module tb_wr_resp_router_2m;
  import wr_resp_router_pkg::*;

  localparam int DEPTH  = 4;
  localparam int RESP_W = 2;
  localparam int W      = RESP_W + 1;

  logic                   ACLK;
  logic                   ARESETN;
  logic                   aw_push;
  logic                   aw_master;
  logic                   aw_ready;
  logic                   M_AXI_bvalid;
  logic [RESP_W-1:0]      M_AXI_bresp;
  logic                   M_AXI_bready;
  logic                   S00_AXI_bvalid;
  logic [RESP_W-1:0]      S00_AXI_bresp;
  logic                   S00_AXI_bready;
  logic                   S01_AXI_bvalid;
  logic [RESP_W-1:0]      S01_AXI_bresp;
  logic                   S01_AXI_bready;
  logic [$clog2(DEPTH):0] outstanding;
  bstate_e                dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observed bundle: {S00 v, S00 resp, S01 v, S01 resp, M bready, aw_ready, outstanding}
  logic [10:0] obs;
  assign obs = {S00_AXI_bvalid, S00_AXI_bresp, S01_AXI_bvalid, S01_AXI_bresp,
                M_AXI_bready, aw_ready, outstanding};

  localparam logic [10:0] IDLE_OBS = {1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0};

  // Model state for the randomized test
  bit          ord_q[$];
  logic [W-1:0] exp_q[$];

  wr_resp_router_2m #(.DEPTH(DEPTH), .RESP_W(RESP_W)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .aw_push        (aw_push),
    .aw_master      (aw_master),
    .aw_ready       (aw_ready),
    .M_AXI_bvalid   (M_AXI_bvalid),
    .M_AXI_bresp    (M_AXI_bresp),
    .M_AXI_bready   (M_AXI_bready),
    .S00_AXI_bvalid (S00_AXI_bvalid),
    .S00_AXI_bresp  (S00_AXI_bresp),
    .S00_AXI_bready (S00_AXI_bready),
    .S01_AXI_bvalid (S01_AXI_bvalid),
    .S01_AXI_bresp  (S01_AXI_bresp),
    .S01_AXI_bready (S01_AXI_bready),
    .outstanding    (outstanding),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic drive_idle();
    aw_push        = 1'b0;
    aw_master      = 1'b0;
    M_AXI_bvalid   = 1'b0;
    M_AXI_bresp    = '0;
    S00_AXI_bready = 1'b1;
    S01_AXI_bready = 1'b1;
  endtask

  task automatic push_master(input bit m);
    aw_push   = 1'b1;
    aw_master = m;
    tick();
    aw_push   = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    ARESETN      = 1'b0;
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if (obs !== IDLE_OBS) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs, IDLE_OBS);
      end
    end
    ARESETN      = 1'b1;
    M_AXI_bvalid = 1'b0;
    tick();
  endtask

  task automatic test_in_order();
    drive_idle();
    push_master(1'b0);
    push_master(1'b1);
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = OKAY;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL in_order_pre: got %b want 00000011010", obs);
    end
    tick();
    M_AXI_bresp = SLVERR;
    #1;
    tests_run++;
    if (obs !== {1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL in_order_s00_okay: got %b want 10000011001", obs);
    end
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL in_order_s01_slverr: got %b want 00011001000", obs);
    end
    tick();
    #1;
    tests_run++;
    if (obs !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL in_order_idle: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_backpressure();
    drive_idle();
    S01_AXI_bready = 1'b0;
    push_master(1'b1);
    // pop m1 and push m0 in the same cycle
    aw_push      = 1'b1;
    aw_master    = 1'b0;
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = EXOKAY;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL bp_accept: got %b want 00000011001", obs);
    end
    tick();
    aw_push     = 1'b0;
    M_AXI_bresp = DECERR;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (obs !== {1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 3'd1}) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got %b want 00010101001", i, obs);
      end
      tick();
    end
    S01_AXI_bready = 1'b1;
    M_AXI_bresp    = SLVERR;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL bp_release: got %b want 00010111001", obs);
    end
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL bp_reload_s00: got %b want 11000001000", obs);
    end
    tick();
    #1;
    tests_run++;
    if (obs !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL bp_idle: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_full();
    logic [10:0] e;
    logic [1:0]  r;
    drive_idle();
    for (int i = 0; i < 4; i++) push_master(i[0]);
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd4}) begin
      tests_failed++;
      $display("FAIL full_flags: got %b want 00000010100", obs);
    end
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) M_AXI_bresp = 2'(i + 1);
      else       M_AXI_bvalid = 1'b0;
      #1;
      r = 2'(i);
      e = {!i[0], (i[0] ? 2'd0 : r), i[0], (i[0] ? r : 2'd0),
           (i < 3), 1'b1, 3'(3 - i)};
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL full_drain resp%0d: got %b want %b", i, obs, e);
      end
    end
    tick();
    #1;
    tests_run++;
    if (obs !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL full_idle: got %b want %b", obs, IDLE_OBS);
    end
  endtask

  task automatic test_stray();
    drive_idle();
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = SLVERR;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (obs !== IDLE_OBS) begin
        tests_failed++;
        $display("FAIL stray cyc%0d: got %b want %b", i, obs, IDLE_OBS);
      end
      tick();
    end
    M_AXI_bvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_idle();
    S00_AXI_bready = 1'b0;
    push_master(1'b0);
    push_master(1'b1);
    push_master(1'b0);
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = DECERR;
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL rstmid_hold: got %b want 11100001010", obs);
    end
    ARESETN = 1'b0;
    tick();
    #1;
    tests_run++;
    if (obs !== IDLE_OBS || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rstmid_clear: got %b st %0d want %b st 0", obs, dbg_state, IDLE_OBS);
    end
    ARESETN = 1'b1;
    push_master(1'b1);
    M_AXI_bvalid = 1'b1;
    M_AXI_bresp  = SLVERR;
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL rstmid_route: got %b want 00011001000", obs);
    end
    S00_AXI_bready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit          held;
    bit          hd;
    logic [1:0]  hr;
    bit          dest_rdy;
    bit          e_mb;
    logic [10:0] e;
    logic [W-1:0] hq;
    drive_idle();
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    ord_q.delete();
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      S00_AXI_bready = ($urandom_range(0, 3) != 0);
      S01_AXI_bready = ($urandom_range(0, 3) != 0);
      M_AXI_bvalid   = ($urandom_range(0, 2) != 0);
      M_AXI_bresp    = 2'($urandom_range(0, 3));
      aw_master      = 1'($urandom_range(0, 1));
      aw_push        = (ord_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      #1;
      held = (exp_q.size() > 0);
      hq   = held ? exp_q[0] : '0;
      hd   = hq[W-1];
      hr   = hq[RESP_W-1:0];
      dest_rdy = hd ? S01_AXI_bready : S00_AXI_bready;
      e_mb = (ord_q.size() > 0) && (!held || dest_rdy);
      e = {held && !hd, (held && !hd) ? hr : 2'd0,
           held && hd,  (held && hd)  ? hr : 2'd0,
           e_mb, (ord_q.size() < DEPTH), 3'(ord_q.size())};
      tests_run++;
      if (obs !== e || dbg_state !== (held ? ST_HOLD : ST_IDLE)) begin
        tests_failed++;
        $display("FAIL random cyc%0d: got %b st %0d want %b st %0d", c, obs, dbg_state, e, held);
      end
      if (held && dest_rdy) void'(exp_q.pop_front());
      if (M_AXI_bvalid && e_mb) exp_q.push_back({ord_q.pop_front(), M_AXI_bresp});
      if (aw_push) ord_q.push_back(aw_master);
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    ARESETN = 1'b0;
    test_reset();
    test_in_order();
    test_backpressure();
    test_full();
    test_stray();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
